// File: rtl/prog_loader_mem.sv
// Synchronous program store for the picoMIPS core. A byte stream loads the memory,
// and a registered read port serves fetches once a complete program is resident.
module prog_loader_mem #(
  parameter int Psize = 4,
  parameter int Isize = 17,
  parameter int Bsize = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [Psize-1:0] address,
  input  logic             rd_en,
  output logic [Isize-1:0] I,
  output logic             I_valid,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [Bsize-1:0] load_data,
  output logic             load_ready,
  output logic             load_busy,
  output logic             load_done
);

  localparam int NB    = (Isize + Bsize - 1) / Bsize;
  localparam int AW    = NB * Bsize;
  localparam int CW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int DEPTH = 2 ** Psize;

  localparam logic [CW-1:0]    LAST_BYTE = CW'(NB - 1);
  localparam logic [Psize-1:0] LAST_WORD = '1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    byte_cnt;
  logic [Psize-1:0] wr_addr;
  logic [AW-1:0]    asm_reg;
  logic [AW-1:0]    asm_next;
  logic             loaded;
  logic [Isize-1:0] mem [DEPTH];

  logic start_load;
  logic xfer;
  logic word_end;
  logic mem_we;

  // A start pulse in LOAD restarts the load and swallows any byte offered with it.
  assign start_load = load_start && (state != DONE);
  assign xfer       = (state == LOAD) && load_valid && !load_start;
  assign word_end   = (byte_cnt == LAST_BYTE);
  assign mem_we     = xfer && word_end;
  assign asm_next   = (asm_reg << Bsize) | AW'(load_data);

  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    load_busy  = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_next = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        load_busy  = 1'b1;
        if (mem_we && (wr_addr == LAST_WORD)) state_next = DONE;
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      wr_addr  <= '0;
      asm_reg  <= '0;
      loaded   <= 1'b0;
    end else begin
      state <= state_next;
      if (start_load) begin
        byte_cnt <= '0;
        wr_addr  <= '0;
        asm_reg  <= '0;
        loaded   <= 1'b0;
      end else if (xfer) begin
        asm_reg <= asm_next;
        if (word_end) begin
          byte_cnt <= '0;
          wr_addr  <= wr_addr + Psize'(1);
        end else begin
          byte_cnt <= byte_cnt + CW'(1);
        end
      end
      if (state == DONE) loaded <= 1'b1;
    end
  end

  // Surplus high bits of the first byte fall off when truncating to Isize.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= asm_next[Isize-1:0];
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      I       <= '0;
      I_valid <= 1'b0;
    end else if (start_load) begin
      I_valid <= 1'b0;
    end else if (rd_en) begin
      if ((state != LOAD) && loaded) begin
        I       <= mem[address];
        I_valid <= 1'b1;
      end else begin
        I_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader_mem.sv
// Scoreboard bench for prog_loader_mem: fetch expectations are queued by the stimulus
// and checked by an independent monitor; load sequencing is checked directly.
module tb_prog_loader_mem;

  localparam int Psize = 4;
  localparam int Isize = 17;
  localparam int Bsize = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             nReset;
  logic [Psize-1:0] address;
  logic             rd_en;
  logic [Isize-1:0] I;
  logic             I_valid;
  logic             load_start;
  logic             load_valid;
  logic [Bsize-1:0] load_data;
  logic             load_ready;
  logic             load_busy;
  logic             load_done;

  typedef struct packed {
    logic             v;
    logic [Isize-1:0] d;
  } exp_t;

  exp_t             sb[$];
  logic [Isize-1:0] exp_mem [DEPTH];

  int n_compared   = 0;
  int n_mismatched = 0;
  int accepted     = 0;
  int done_pulses  = 0;
  int ready_err    = 0;
  logic pend;

  prog_loader_mem #(.Psize(Psize), .Isize(Isize), .Bsize(Bsize)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .address    (address),
    .rd_en      (rd_en),
    .I          (I),
    .I_valid    (I_valid),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Byte patterns: 0 = {00,k,5A}; 1 = alternate program; 2 = pattern 0 with word 0 = FF,12,34; 3 = junk.
  function automatic logic [7:0] pat(input int seed, input int k, input int j);
    logic [7:0] kb;
    kb = 8'(k);
    if (seed == 1) begin
      if (j == 0)      return 8'h01;
      else if (j == 1) return 8'hC0 | kb;
      else             return kb ^ 8'h3C;
    end else if (seed == 2 && k == 0) begin
      if (j == 0)      return 8'hFF;
      else if (j == 1) return 8'h12;
      else             return 8'h34;
    end else if (seed == 3) begin
      return 8'hA0 + 8'(j * 16 + k);
    end else begin
      if (j == 0)      return 8'h00;
      else if (j == 1) return kb;
      else             return 8'h5A;
    end
  endfunction

  // Monitor: every edge that saw rd_en high owes one queued expectation.
  always begin
    exp_t e;
    @(posedge clk);
    pend = rd_en && nReset;
    @(negedge clk);
    if (pend) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL sb_underflow: actual=fetch required=queued expectation");
      end else begin
        e = sb.pop_front();
        check_output("fetch_valid", 32'(I_valid), 32'(e.v));
        check_output("fetch_data", 32'(I), 32'(e.d));
      end
    end
  end

  always @(posedge clk) begin
    if (nReset && load_valid && load_ready && !load_start) accepted++;
  end

  always @(negedge clk) begin
    if (load_done) done_pulses++;
    if (load_busy && !load_ready) ready_err++;
  end

  task automatic fetch(input int addr, input logic v, input logic [Isize-1:0] d);
    exp_t e;
    e.v = v;
    e.d = d;
    address = Psize'(addr);
    rd_en   = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hEE;
    @(negedge clk);
    load_start = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic stream_partial(input int seed, input int n);
    pulse_start();
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = pat(seed, i / 3, i % 3);
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  task automatic run_load(input int seed, input bit gap, input bit start_in_done);
    int base_acc, base_done, base_rerr, cyc;
    logic [23:0] w;
    base_acc  = accepted;
    base_done = done_pulses;
    base_rerr = ready_err;
    pulse_start();
    check_output("valid_clear_on_start", 32'(I_valid), 0);
    cyc = 0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int j = 0; j < 3; j++) begin
        load_valid = 1'b1;
        load_data  = pat(seed, k, j);
        @(negedge clk);
        cyc++;
        if (gap && !(k == DEPTH - 1 && j == 2)) begin
          load_valid = 1'b0;
          @(negedge clk);
          cyc++;
        end
      end
      w = {pat(seed, k, 0), pat(seed, k, 1), pat(seed, k, 2)};
      exp_mem[k] = w[Isize-1:0];
    end
    load_valid = 1'b0;
    check_output("load_done_at_end", 32'(load_done), 1);
    check_output("done_cycle", 32'(cyc + 1), gap ? 32'd96 : 32'd49);
    check_output("bytes_accepted", 32'(accepted - base_acc), 48);
    if (start_in_done) load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check_output("done_pulses", 32'(done_pulses - base_done), 1);
    check_output("busy_after_done", 32'(load_busy), 0);
    check_output("ready_in_load", 32'(ready_err - base_rerr), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nReset     = 1'b0;
    address    = '0;
    rd_en      = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    repeat (2) @(negedge clk);
    check_output("rst_I", 32'(I), 0);
    check_output("rst_I_valid", 32'(I_valid), 0);
    check_output("rst_load_ready", 32'(load_ready), 0);
    check_output("rst_load_busy", 32'(load_busy), 0);
    check_output("rst_load_done", 32'(load_done), 0);
    rd_en  = 1'b0;
    nReset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      fetch(0, 1'b0, 17'h0);
      check_output("unloaded_busy", 32'(load_busy), 0);
    end

    $display("[TB] full gap-free load");
    run_load(0, 1'b0, 1'b1);
    fetch(3, 1'b1, 17'h0035A);
    fetch(0, 1'b1, exp_mem[0]);
    fetch(15, 1'b1, 17'h00F5A);

    $display("[TB] discarded high bits");
    run_load(2, 1'b0, 1'b0);
    fetch(0, 1'b1, 17'h11234);
    fetch(1, 1'b1, 17'h0015A);

    $display("[TB] gapped load");
    run_load(0, 1'b1, 1'b0);
    for (int k = 0; k < DEPTH; k++) fetch(k, 1'b1, exp_mem[k]);
    check_output("gap_word0", 32'(exp_mem[0]), 32'h0005A);

    $display("[TB] restart mid-load");
    stream_partial(3, 20);
    run_load(1, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) fetch(k, 1'b1, exp_mem[k]);

    $display("[TB] reset mid-load");
    stream_partial(3, 10);
    nReset = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    check_output("rst_mid_busy", 32'(load_busy), 0);
    check_output("rst_mid_valid", 32'(I_valid), 0);
    fetch(2, 1'b0, 17'h0);
    fetch(7, 1'b0, 17'h0);
    run_load(0, 1'b0, 1'b0);
    fetch(2, 1'b1, 17'h0025A);

    $display("[TB] fetch hold");
    fetch(5, 1'b1, 17'h0055A);
    address = 4'd9;
    rd_en   = 1'b0;
    repeat (2) @(negedge clk);
    check_output("hold_I", 32'(I), 32'h0055A);
    check_output("hold_valid", 32'(I_valid), 1);

    repeat (2) @(negedge clk);
    check_output("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
